mm_drain: RTL and testbench
===========================

Name: mm_drain

Overview:
- Output-side companion of the matrix-multiply block.
- Captures the N*N systolic results (exp, acc) when that block signals done.
- Serializes the captured results one element per cycle over a valid/ready stream toward the writeback path.
- Reports busy so the controller holds off the next active pulse until the drain finishes.

Parameters:
- ACC_WIDTH, 32, width of each accumulator result.
- EXP_WIDTH, 5, width of each exponent result.
- N, 2, array dimension; N*N results per tile.
- IDX_W, max(1, clog2(N*N)), width of out_idx.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- done  in  1  completion level from the matrix block; may stay high for many cycles.
- exp_in  in  N*N*EXP_WIDTH  flattened exponents; element k at bits [k*EXP_WIDTH +: EXP_WIDTH].
- acc_in  in  N*N*ACC_WIDTH  flattened accumulators; element k at bits [k*ACC_WIDTH +: ACC_WIDTH].
- out_ready  in  1  downstream accept.
- ovf_clr  in  1  synchronous clear of the overrun flag.
- out_valid  out  1  stream element valid.
- out_exp  out  EXP_WIDTH  current element exponent.
- out_acc  out  ACC_WIDTH  current element accumulator.
- out_idx  out  IDX_W  element index k = row*N + col.
- out_last  out  1  high with element N*N-1.
- busy  out  1  drain holds an uncommitted tile.
- overrun  out  1  sticky; a done rise was dropped.

Behaviour:
- Reset values, asserted asynchronously:
  - State IDLE.
  - out_valid, out_exp, out_acc, out_idx, out_last, busy, overrun all 0.
  - Capture registers 0.
  - done_q = 1, so a done held high through reset is not captured; done must fall and rise again.
- Edge detect: rise = done & ~done_q; done_q <= done every cycle.
- State IDLE:
  - On a rise edge: register all N*N exp/acc into capture storage, idx <= 0, go to STREAM.
  - out_valid = 1 starting in the cycle after the capture edge (latency 1).
- State STREAM:
  - out_valid = 1; out_exp/out_acc = capture[idx]; out_idx = idx; out_last = (idx == N*N-1).
  - Transfer occurs at a posedge with out_valid & out_ready; then idx <= idx+1.
  - out_ready low: hold all outputs stable, with no bubbles and no drops.
  - Transfer with out_last: return to IDLE; out_valid = 0 next cycle.
- busy = (state == STREAM). Combinational from state; high from the cycle after capture through the cycle of the last transfer.
- Boundaries:
  - Rise while STREAM, not on the last-transfer edge: the new tile is dropped, overrun <= 1, and the current stream is undisturbed.
  - Rise on the same edge as the last transfer: capture the new tile, idx <= 0, stay in STREAM. out_valid stays 1 and no overrun is raised.
  - ovf_clr with a simultaneous overrun event: set wins (overrun stays 1).
  - Reset mid-stream: outputs drop to 0 immediately; the partial tile is lost with no further elements.
  - N=1: a single element per tile, with out_last high on it.
- Inputs exp_in/acc_in are sampled only on the capture edge and may change afterwards.

Test Plan:
- N=2 load: acc_in = {40,30,20,10}, exp_in = {4,3,2,1}, done 0->1, out_ready = 1 → out_valid from the next cycle.
  - Elements idx 0..3 arrive as (1,10), (2,20), (3,30), (4,40) on 4 consecutive cycles.
  - out_last only on idx 3; busy high exactly 4 cycles; then IDLE.
- Backpressure: same tile, out_ready toggling 1,0,0,1,0,1,1 → exactly 4 transfers in order.
  - Outputs stay stable while out_ready = 0; busy drops after the 4th transfer.
- Level done: done held high 20 cycles → exactly one tile streamed, overrun = 0.
- Overrun: second done rise at transfer 2 of 4 → the stream completes with the original values and overrun = 1.
  - ovf_clr pulse → overrun = 0.
- Back-to-back: second rise on the edge of the idx-3 transfer with new acc {80,70,60,50} → out_valid never drops.
  - Next element is idx 0 with acc 50; overrun = 0.
- Reset: assert rst after 2 transfers → out_valid/busy go 0 asynchronously.
  - With done still high after release, no stream starts until done falls and rises again.

Source files
------------

// File: rtl/mm_drain.sv
// Captures an N*N tile of (exp, acc) results on a rising done level and
// streams it out one element per cycle over a valid/ready handshake.
module mm_drain #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned EXP_WIDTH = 5,
  parameter int unsigned N         = 2,
  parameter int unsigned IDX_W     = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         done_i,
  input  logic [N*N*EXP_WIDTH-1:0]     exp_in_i,
  input  logic [N*N*ACC_WIDTH-1:0]     acc_in_i,
  input  logic                         out_ready_i,
  input  logic                         ovf_clr_i,
  output logic                         out_valid_o,
  output logic [EXP_WIDTH-1:0]         out_exp_o,
  output logic [ACC_WIDTH-1:0]         out_acc_o,
  output logic [IDX_W-1:0]             out_idx_o,
  output logic                         out_last_o,
  output logic                         busy_o,
  output logic                         overrun_o
);

  localparam int unsigned NumElem = N * N;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NumElem - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e               state_q;
  logic                 done_q;
  logic                 overrun_q;
  logic [IDX_W-1:0]     idx_q;
  logic [EXP_WIDTH-1:0] exp_q [NumElem];
  logic [ACC_WIDTH-1:0] acc_q [NumElem];

  logic streaming, rise, xfer, last_xfer, capture, ovf_set;

  always_comb begin
    streaming = (state_q == StStream);
    rise      = done_i & ~done_q;
    xfer      = streaming & out_ready_i;
    last_xfer = xfer & (idx_q == LastIdx);
    // A new tile is only accepted when the storage is free or frees up on this edge.
    capture   = rise & (~streaming | last_xfer);
    ovf_set   = rise & streaming & ~last_xfer;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      done_q    <= 1'b1;
      overrun_q <= 1'b0;
      idx_q     <= '0;
      for (int unsigned k = 0; k < NumElem; k++) begin
        exp_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      done_q <= done_i;

      if (ovf_set) begin
        overrun_q <= 1'b1;
      end else if (ovf_clr_i) begin
        overrun_q <= 1'b0;
      end

      if (capture) begin
        for (int unsigned k = 0; k < NumElem; k++) begin
          exp_q[k] <= exp_in_i[k*EXP_WIDTH +: EXP_WIDTH];
          acc_q[k] <= acc_in_i[k*ACC_WIDTH +: ACC_WIDTH];
        end
        idx_q   <= '0;
        state_q <= StStream;
      end else if (xfer) begin
        if (idx_q == LastIdx) begin
          state_q <= StIdle;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    out_valid_o = streaming;
    busy_o      = streaming;
    out_exp_o   = streaming ? exp_q[idx_q] : '0;
    out_acc_o   = streaming ? acc_q[idx_q] : '0;
    out_idx_o   = streaming ? idx_q : '0;
    out_last_o  = streaming & (idx_q == LastIdx);
    overrun_o   = overrun_q;
  end

endmodule

// File: tb/tb_mm_drain.sv
// Bench for mm_drain: directed steps plus random traffic, checked against a
// queue-based model of the pending elements of the tile being drained.
module tb_mm_drain;

  localparam int AW = 32;
  localparam int EW = 5;
  localparam int NN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             done, out_ready, ovf_clr;
  logic [NN*EW-1:0] exp_in;
  logic [NN*AW-1:0] acc_in;
  logic             out_valid, out_last, busy, overrun;
  logic [EW-1:0]    out_exp;
  logic [AW-1:0]    out_acc;
  logic [1:0]       out_idx;

  mm_drain #(.ACC_WIDTH(AW), .EXP_WIDTH(EW), .N(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .done_i      (done),
    .exp_in_i    (exp_in),
    .acc_in_i    (acc_in),
    .out_ready_i (out_ready),
    .ovf_clr_i   (ovf_clr),
    .out_valid_o (out_valid),
    .out_exp_o   (out_exp),
    .out_acc_o   (out_acc),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] e;
    logic [AW-1:0] a;
    int            idx;
  } elem_t;

  // Model: elements still owed to the stream, overrun flag, previous done level.
  elem_t q[$];
  logic  m_ovf;
  logic  m_done;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NN*EW-1:0] pack_exp(input int e0, e1, e2, e3);
    return {EW'(e3), EW'(e2), EW'(e1), EW'(e0)};
  endfunction

  function automatic logic [NN*AW-1:0] pack_acc(input int a0, a1, a2, a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = (q.size() > 0);
    chk("valid", {31'd0, out_valid}, {31'd0, ev});
    chk("busy", {31'd0, busy}, {31'd0, ev});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovf});
    if (ev) begin
      chk("exp", {27'd0, out_exp}, {27'd0, q[0].e});
      chk("acc", out_acc, q[0].a);
      chk("idx", {30'd0, out_idx}, 32'(q[0].idx));
      chk("last", {31'd0, out_last}, {31'd0, (q[0].idx == NN - 1)});
    end
  endtask

  // Apply the inputs for one clock edge and advance the model across it.
  task automatic cycle(input logic d, input logic r, input logic c,
                       input logic [NN*EW-1:0] e, input logic [NN*AW-1:0] a);
    logic rise, xfer, last_x, set;
    check_outputs();
    done = d; out_ready = r; ovf_clr = c; exp_in = e; acc_in = a;
    rise   = d && !m_done;
    xfer   = (q.size() > 0) && r;
    last_x = xfer && (q.size() == 1);
    set    = rise && (q.size() > 0) && !last_x;
    if (xfer) void'(q.pop_front());
    if (rise && !set) begin
      for (int k = 0; k < NN; k++) begin
        elem_t el;
        el.e = e[k*EW +: EW];
        el.a = a[k*AW +: AW];
        el.idx = k;
        q.push_back(el);
      end
    end
    if (set) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_done = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [NN*EW-1:0] ea, eb;
    logic [NN*AW-1:0] aa, ab;
    logic [6:0]       bp;
    logic             dr;
    ea = pack_exp(1, 2, 3, 4);
    aa = pack_acc(10, 20, 30, 40);
    eb = pack_exp(5, 6, 7, 8);
    ab = pack_acc(50, 60, 70, 80);
    bp = 7'b1101001;  // ready pattern 1,0,0,1,0,1,1 read from bit 0 upwards

    rst = 1'b1; done = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    exp_in = '0; acc_in = '0;
    q.delete(); m_ovf = 1'b0; m_done = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overrun}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_idx", {30'd0, out_idx}, 32'd0);
    chk("rst_exp", {27'd0, out_exp}, 32'd0);
    chk("rst_acc", out_acc, 32'd0);
    rst = 1'b0;

    // Plain load with ready held high.
    cycle(1'b0, 1'b1, 1'b0, ea, aa);
    cycle(1'b1, 1'b1, 1'b0, ea, aa);
    chk("load_lat_valid", {31'd0, out_valid}, 32'd1);
    chk("load_first_acc", out_acc, 32'd10);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, ea, aa);
    chk("load_last", {31'd0, out_last}, 32'd1);
    chk("load_last_acc", out_acc, 32'd40);
    cycle(1'b1, 1'b1, 1'b0, ea, aa);
    chk("load_idle", {31'd0, busy}, 32'd0);

    // Backpressure.
    cycle(1'b0, 1'b1, 1'b0, ea, aa);
    cycle(1'b1, 1'b0, 1'b0, ea, aa);
    for (int i = 0; i < 7; i++) cycle(1'b0, bp[i], 1'b0, '0, '0);
    chk("bp_done", {31'd0, busy}, 32'd0);

    // Level done: one tile only.
    cycle(1'b0, 1'b1, 1'b0, ea, aa);
    repeat (20) cycle(1'b1, 1'b1, 1'b0, ea, aa);
    chk("level_ovf", {31'd0, overrun}, 32'd0);
    chk("level_idle", {31'd0, out_valid}, 32'd0);

    // Overrun on the second transfer, then clear.
    cycle(1'b0, 1'b1, 1'b0, ea, aa);
    cycle(1'b1, 1'b1, 1'b0, ea, aa);
    cycle(1'b0, 1'b1, 1'b0, ea, aa);
    cycle(1'b1, 1'b1, 1'b0, eb, ab);
    chk("ovf_set", {31'd0, overrun}, 32'd1);
    chk("ovf_orig_acc", out_acc, 32'd30);
    cycle(1'b1, 1'b1, 1'b0, eb, ab);
    cycle(1'b1, 1'b1, 1'b0, eb, ab);
    chk("ovf_stream_end", {31'd0, busy}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, '0, '0);
    chk("ovf_clr", {31'd0, overrun}, 32'd0);

    // Back-to-back tiles: rise on the last-transfer edge.
    cycle(1'b1, 1'b1, 1'b0, ea, aa);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, '0);
    chk("b2b_idx3", {30'd0, out_idx}, 32'd3);
    cycle(1'b1, 1'b1, 1'b0, eb, ab);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_idx0", {30'd0, out_idx}, 32'd0);
    chk("b2b_acc", out_acc, 32'd50);
    chk("b2b_ovf", {31'd0, overrun}, 32'd0);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0, '0);

    // Asynchronous reset mid-stream with done held high.
    cycle(1'b1, 1'b1, 1'b0, ea, aa);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, ea, aa);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    q.delete(); m_ovf = 1'b0; m_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, ea, aa);
    chk("arst_no_restart", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, ea, aa);
    cycle(1'b1, 1'b1, 1'b0, ea, aa);
    chk("arst_restart_acc", out_acc, 32'd10);

    // Random traffic against the model.
    dr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [NN*AW-1:0] ar;
      if ($urandom_range(0, 4) == 0) dr = ~dr;
      ar = {$urandom, $urandom, $urandom, $urandom};
      cycle(dr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            NN*EW'($urandom), ar);
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
